// File: rtl/ahbmtx_pkg.sv
// Shared AHB matrix definitions: response/transfer encodings and the error-slave FSM states.
package ahbmtx_pkg;

    typedef enum logic [1:0] {
        RSP_OKAY  = 2'b00,
        RSP_ERROR = 2'b01,
        RSP_RETRY = 2'b10,
        RSP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        TRN_IDLE   = 2'b00,
        TRN_BUSY   = 2'b01,
        TRN_NONSEQ = 2'b10,
        TRN_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } err_state_e;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never do.
    function automatic logic trans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahbmtx_err_log.sv
// First-fault capture, saturating error counter and sticky IRQ for the matrix error slave.
module ahbmtx_err_log
    import ahbmtx_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              accept_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              write_i,
    input  logic              clr_i,
    output logic              irq_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              write_o,
    output logic [CNT_W-1:0]  count_o
);

    logic              irq_q,   irq_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              write_q, write_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_comb begin
        irq_d   = irq_q;
        addr_d  = addr_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        if (accept_i) begin
            // A clear coinciding with a new fault restarts the log with that fault.
            irq_d = 1'b1;
            if (!irq_q || clr_i) begin
                addr_d  = addr_i;
                write_d = write_i;
            end
            if (clr_i) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clr_i) begin
            irq_d   = 1'b0;
            addr_d  = '0;
            write_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q   <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            irq_q   <= irq_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    assign irq_o   = irq_q;
    assign addr_o  = addr_q;
    assign write_o = write_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/ahbmtx_err_slave.sv
// AHB matrix default slave: ERROR for every NONSEQ/SEQ after WAIT_CYCLES wait states.
// Define ERRSLV_LOG_EN to build the fault log (ERR_* outputs); otherwise they read as 0.
module ahbmtx_err_slave
    import ahbmtx_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [1:0]        HTRANS,
    input  logic              HREADY,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    output logic              HREADYOUT,
    output logic [1:0]        HRESP,
    input  logic              ERR_CLR,
    output logic              ERR_IRQ,
    output logic [ADDR_W-1:0] ERR_ADDR,
    output logic              ERR_WRITE,
    output logic [CNT_W-1:0]  ERR_COUNT
);

    err_state_e state_q, state_d;
    logic       accept;
    logic       ready_q;
    logic       wait_done;

    assign accept  = HSEL & HREADY & trans_active(HTRANS);
    assign ready_q = (state_q == ST_IDLE) || (state_q == ST_ERR2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ERR1;
            end
            ST_WAIT: begin
                if (wait_done) state_d = ST_ERR1;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: begin
                if (accept) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ERR1;
                else        state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    generate
        if (WAIT_CYCLES > 0) begin : g_wait
            localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
            logic [WCW-1:0] wcnt_q, wcnt_d;

            // Loaded on the accept edge so the WAIT state lasts exactly WAIT_CYCLES cycles.
            always_comb begin
                wcnt_d = wcnt_q;
                if (accept && ready_q) begin
                    wcnt_d = WCW'(WAIT_CYCLES - 1);
                end else if ((state_q == ST_WAIT) && (wcnt_q != '0)) begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) wcnt_q <= '0;
                else          wcnt_q <= wcnt_d;
            end

            assign wait_done = (wcnt_q == '0);
        end else begin : g_nowait
            assign wait_done = 1'b1;
        end
    endgenerate

    assign HREADYOUT = ready_q;
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? RSP_ERROR : RSP_OKAY;

`ifdef ERRSLV_LOG_EN
    ahbmtx_err_log #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_log (
        .clk_i    (HCLK),
        .rst_ni   (HRESETn),
        .accept_i (accept),
        .addr_i   (HADDR),
        .write_i  (HWRITE),
        .clr_i    (ERR_CLR),
        .irq_o    (ERR_IRQ),
        .addr_o   (ERR_ADDR),
        .write_o  (ERR_WRITE),
        .count_o  (ERR_COUNT)
    );
`else
    logic unused_log_inputs;
    assign unused_log_inputs = ^{ERR_CLR, HADDR, HWRITE};

    assign ERR_IRQ   = 1'b0;
    assign ERR_ADDR  = '0;
    assign ERR_WRITE = 1'b0;
    assign ERR_COUNT = '0;
`endif

endmodule

// File: doc/ahbmtx_err_slave.md
# ahbmtx_err_slave

Parametrised successor to the matrix default slave. Sits behind every unmapped address region of an AHB matrix output stage and answers any NONSEQ/SEQ transfer with a two-cycle ERROR response, after a configurable number of wait states. IDLE and BUSY transfers get a zero-wait OKAY. Optionally logs the first faulting access (address, direction) and counts errors, raising a sticky interrupt for the system controller.

## Interface
- ADDR_W, 32, HADDR and ERR_ADDR width
- WAIT_CYCLES, 0, OKAY wait states inserted before the ERROR response (legal 0..15; 0 = legacy timing)
- CNT_W, 8, error counter width (saturating)
- HCLK  in  1  AHB system clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HTRANS  in  2  transfer type
- HREADY  in  1  bus transfer done
- HADDR  in  ADDR_W  address phase address
- HWRITE  in  1  address phase direction
- HREADYOUT  out  1  ready feedback
- HRESP  out  2  response (00 OKAY, 01 ERROR)
- ERR_CLR  in  1  single-cycle clear of IRQ, log and counter
- ERR_IRQ  out  1  sticky error flag
- ERR_ADDR  out  ADDR_W  first faulting HADDR since last clear
- ERR_WRITE  out  1  HWRITE of that access
- ERR_COUNT  out  CNT_W  errors since last clear

## Operation
- accept = HSEL & HREADY & HTRANS[1]. An accept in a state that drives HREADYOUT=1 starts an error sequence.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=OKAY. accept → WAIT if WAIT_CYCLES>0, else ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Exit to ERR1 when the counter is 0.
  - ERR1: HREADYOUT=0, HRESP=ERROR. → ERR2 unconditionally.
  - ERR2: HREADYOUT=1, HRESP=ERROR.
    - accept → WAIT/ERR1 (back-to-back error).
    - No accept → IDLE.
- IDLE/BUSY with HSEL, or HSEL low: no state change, OKAY.
- The wait counter is $clog2(WAIT_CYCLES+1) bits (minimum 1). It is not instantiated when WAIT_CYCLES=0.
- Log:
  - On accept with ERR_IRQ=0, capture HADDR→ERR_ADDR and HWRITE→ERR_WRITE.
  - On accept with ERR_IRQ=1, ERR_ADDR and ERR_WRITE hold (first error kept).
  - ERR_COUNT increments on every accept and saturates at all-ones.
  - ERR_IRQ sets on accept.
- ERR_CLR in the same cycle as an accept: the new error wins. Result: ERR_IRQ=1, log captures the new access, ERR_COUNT=1.
- ERR_CLR alone: IRQ=0, ERR_ADDR=0, ERR_WRITE=0, COUNT=0. The response FSM is unaffected.

## Timing
- Reset (async assert, sync deassert by HCLK):
  - State=IDLE.
  - HREADYOUT=1, HRESP=00.
  - ERR_IRQ=0, ERR_ADDR=0, ERR_WRITE=0, ERR_COUNT=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency from the accept edge: WAIT_CYCLES cycles of HREADYOUT=0/OKAY, then 1 cycle HREADYOUT=0/ERROR, then 1 cycle HREADYOUT=1/ERROR. Total data phase = WAIT_CYCLES+2 cycles.
- Log/IRQ/counter update on the clock edge that samples the accept, visible the next cycle.
- Reset mid-sequence: immediate return to IDLE values. The master's transfer is abandoned per AHB reset rules.

## Configuration
- ERRSLV_LOG_EN defined: ERR_CLR, ERR_IRQ, ERR_ADDR, ERR_WRITE and ERR_COUNT are present and functional as above.
- ERRSLV_LOG_EN undefined:
  - The log sub-module is not instantiated.
  - ERR_IRQ, ERR_ADDR, ERR_WRITE and ERR_COUNT are tied to 0.
  - ERR_CLR is ignored.
  - The response FSM and its timing are identical in both builds.

## Structure
- Shared package ahbmtx_pkg:
  - HRESP encodings RSP_OKAY/RSP_ERROR/RSP_RETRY/RSP_SPLIT.
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - FSM state enum (IDLE, WAIT, ERR1, ERR2).
- Sub-module ahbmtx_err_log holds the capture registers, saturating counter and IRQ. Its inputs are accept, HADDR, HWRITE and ERR_CLR.
- Top level holds the FSM and wait counter only.

## Test plan
- WAIT_CYCLES=0, NONSEQ to 0x4000_0000, write → HREADYOUT 0,1 with HRESP 01,01. ERR_IRQ=1, ERR_ADDR=0x4000_0000, ERR_WRITE=1, COUNT=1.
- WAIT_CYCLES=3, NONSEQ read → 3 cycles HREADYOUT=0/OKAY, then ERR1, ERR2. IDLE afterwards → HREADYOUT=1/OKAY.
- Back-to-back NONSEQ 0x10 then SEQ 0x14, second accepted in ERR2 → two full error sequences, COUNT=2, ERR_ADDR stays 0x10.
- IDLE and BUSY with HSEL=1, and NONSEQ with HREADY=0 → HREADYOUT=1, HRESP=00, COUNT unchanged.
- CNT_W=2, 5 errors → COUNT=3. ERR_CLR coincident with a 6th accept at 0x20 → COUNT=1, IRQ=1, ERR_ADDR=0x20.
- HRESETn asserted during ERR1 → HREADYOUT=1, HRESP=00 and all log outputs 0 immediately. Build without ERRSLV_LOG_EN → log outputs always 0, response timing identical.
